// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg : definitions shared by the mul/div datapath slot
// Revision   : 1.0  initial release
// ============================================================================
package muldiv_pkg;

  localparam int c_width = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [c_width-1:0] c_dbz_quo = '1;

endpackage
`default_nettype wire

// File: rtl/div_abs.sv
`default_nettype none
// ============================================================================
// div_abs  : combinational conditional two's-complement negate
// Revision : 1.0  initial release
// ============================================================================
module div_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? -x : x;

endmodule
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ============================================================================
// div      : iterative restoring divider, one quotient bit per clock,
//            y = {remainder, quotient}. Option macro: DIV_ZERO_FLAG_EN (dbz).
// Revision : 1.0  initial release
// ============================================================================
module div #(
  parameter int WIDTH = muldiv_pkg::c_width
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] y,
  output logic               busy,
  output logic               done
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic               dbz
`endif
);

  import muldiv_pkg::*;

  localparam int c_cnt_w = $clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_next;
  logic [c_cnt_w-1:0] r_count;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_absb;
  logic               r_signed;
  logic               r_sa;
  logic               r_sb;
  logic               r_zero;

  logic               w_sa;
  logic               w_sb;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_absa;
  logic [WIDTH-1:0]   w_absb;
  logic [WIDTH-1:0]   w_qfix;
  logic [WIDTH-1:0]   w_rfix;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_sub;
  logic               w_ge;

  assign w_sa     = is_signed & a[WIDTH-1];
  assign w_sb     = is_signed & b[WIDTH-1];
  assign w_b_zero = (b == '0);

  // Magnitudes are read as unsigned, so -2^(W-1) maps to 2^(W-1) exactly.
  div_abs #(.W(WIDTH)) u_abs_a (.x(a), .neg(w_sa), .y(w_absa));
  div_abs #(.W(WIDTH)) u_abs_b (.x(b), .neg(w_sb), .y(w_absb));

  div_abs #(.W(WIDTH)) u_fix_q (.x(r_quo), .neg(r_signed & (r_sa ^ r_sb)), .y(w_qfix));
  div_abs #(.W(WIDTH)) u_fix_r (.x(r_rem), .neg(r_signed & r_sa),          .y(w_rfix));

  // The difference is always below |b|, so modulo-2^W subtraction is exact.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_absb});
  assign w_sub   = w_shift[WIDTH-1:0] - r_absb;

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_b_zero ? FIX : CALC;
      CALC:    if (r_count == c_cnt_w'(1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_absb   <= '0;
      r_signed <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_zero   <= 1'b0;
      y        <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_signed <= is_signed;
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_absb   <= w_absb;
            r_count  <= c_cnt_w'(WIDTH);
            r_zero   <= w_b_zero;
            if (w_b_zero) begin
              r_rem <= a;
              r_quo <= '1;
            end else begin
              r_rem <= '0;
              r_quo <= w_absa;
            end
          end
        end
        CALC: begin
          r_rem   <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_quo   <= {r_quo[WIDTH-2:0], w_ge};
          r_count <= r_count - c_cnt_w'(1);
        end
        FIX: begin
          y    <= r_zero ? {r_rem, r_quo} : {w_rfix, w_qfix};
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                dbz <= 1'b0;
    else if (r_state == FIX) dbz <= r_zero;
  end
`else
  // No flag output; the divide-by-zero result itself is unchanged.
`endif

endmodule
`default_nettype wire
